// File: rtl/actuator_tx_pkg.sv
// Shared FSM encoding, line levels and counter-width helper for the actuator word transmitter.
// Latency: none (definitions only).
// Backpressure: not applicable.
package actuator_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int cnt_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/actuator_tx_baud_gen.sv
// Baud counter: counts 0..BAUD_DIV-1 and flags the last cycle of each serial bit.
// Latency: o_bit_end is combinational from the count register.
// Backpressure: none; i_clear holds the count at zero.
module actuator_tx_baud_gen
    import actuator_tx_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int            CW   = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_bit_end = (r_cnt == LAST);

    // Wrapping on bit_end keeps the count inside 0..BAUD_DIV-1 even for non-power-of-two dividers.
    always_ff @(posedge CLK) begin
        if (RST || i_clear || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/actuator_word_tx.sv
// Serial transmitter for the control word: start, N data bits LSB first, [parity], stop.
// Latency: start bit 1 cycle after LOAD accept; DONE (N+2[+1])*BAUD_DIV+1 cycles after accept.
// Backpressure: READY=0 while a frame is in flight, LOAD ignored; ACTUATOR_WORD_TX_PARITY_EN adds even parity.
module actuator_word_tx
    import actuator_tx_pkg::*;
#(
    parameter int N        = 8,
    parameter int BAUD_DIV = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] DATA_IN,
    input  logic         LOAD,
    output logic         READY,
    output logic         TX,
    output logic         DONE
);

    localparam int            BW       = cnt_width(N);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    tx_state_t     r_state;
    logic [N-1:0]  r_shift;
    logic [BW-1:0] r_bit_cnt;
    logic          r_tx;
    logic          r_ready;
    logic          r_done;
`ifdef ACTUATOR_WORD_TX_PARITY_EN
    logic          r_parity;
`endif

    logic          w_bit_end;
    logic          w_baud_clear;
    logic [N-1:0]  w_shift_nxt;

    assign w_baud_clear = (r_state == ST_IDLE);
    assign w_shift_nxt  = r_shift >> 1;

    actuator_tx_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .CLK       (CLK),
        .RST       (RST),
        .i_clear   (w_baud_clear),
        .o_bit_end (w_bit_end)
    );

    // Outputs are registered alongside the state, so TX/READY/DONE change on the same edge as the FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= LINE_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
`ifdef ACTUATOR_WORD_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx    <= LINE_IDLE;
                    r_ready <= 1'b1;
                    if (LOAD) begin
                        r_shift  <= DATA_IN;
`ifdef ACTUATOR_WORD_TX_PARITY_EN
                        r_parity <= ^DATA_IN;
`endif
                        r_state  <= ST_START;
                        r_tx     <= START_BIT;
                        r_ready  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef ACTUATOR_WORD_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_tx    <= STOP_BIT;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shift_nxt;
                            r_tx      <= w_shift_nxt[0];
                        end
                    end
                end
`ifdef ACTUATOR_WORD_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_tx    <= STOP_BIT;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_state <= ST_IDLE;
                        r_tx    <= LINE_IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= LINE_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign TX    = r_tx;
    assign READY = r_ready;
    assign DONE  = r_done;

endmodule

// File: tb/tb_actuator_word_tx.sv
// Bench for actuator_word_tx: frame table, hand-built reset/back-to-back sequences, random words vs a frame model.
module tb_actuator_word_tx;

    localparam int N = 8;
    localparam int B = 4;
`ifdef ACTUATOR_WORD_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = N + 2 + PAR;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] DATA_IN;
    logic       LOAD;
    logic       READY, TX, DONE;
    logic [7:0] DATA1;
    logic       LOAD1;
    logic       READY1, TX1, DONE1;

    always #5 CLK = ~CLK;

    actuator_word_tx #(.N(N), .BAUD_DIV(B)) dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD(LOAD),
        .READY(READY), .TX(TX), .DONE(DONE)
    );

    actuator_word_tx #(.N(N), .BAUD_DIV(1)) dut1 (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA1), .LOAD(LOAD1),
        .READY(READY1), .TX(TX1), .DONE(DONE1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level in cycle k (k=1 is the first cycle after the accepting edge).
    function automatic logic exp_tx(input logic [7:0] w, input int k, input int bdiv);
        int b;
        b = (k - 1) / bdiv;
        if (b == 0) return 1'b0;
        if (b <= N) return w[b-1];
        if (PAR == 1 && b == N + 1) return ^w;
        return 1'b1;
    endfunction

    // mode 0: plain; 1: LOAD=3C during data bits; 2: LOAD held with nxt for a chained frame.
    task automatic frame(input logic [7:0] w, input int mode, input logic [7:0] nxt,
                         output int done_at, output logic after_data);
        check("ready_before_load", READY, 1);
        LOAD    = 1'b1;
        DATA_IN = w;
        done_at = -1;
        after_data = 1'bx;
        for (int k = 1; k <= FL * B + 1; k++) begin
            @(negedge CLK);
            check("tx", TX, exp_tx(w, k, B));
            check("ready", READY, (k == FL * B + 1));
            check("done", DONE, (k == FL * B + 1));
            if (DONE === 1'b1 && done_at < 0) done_at = k;
            if (k == (N + 1) * B + B / 2 + 1) after_data = TX;
            case (mode)
                1: begin
                    LOAD    = (k >= B + 1 && k < (N + 1) * B);
                    DATA_IN = 8'h3C;
                end
                2: begin
                    LOAD    = 1'b1;
                    DATA_IN = nxt;
                end
                default: LOAD = 1'b0;
            endcase
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("idle_tx", TX, 1);
            check("idle_done", DONE, 0);
        end
    endtask

    typedef struct {
        logic [7:0] w;
        int         mode;
        logic [7:0] nxt;
        int         exp_done;
        logic       exp_after;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int         done_at;
        logic       after;
        logic [7:0] w;
        logic [7:0] nxt;
        int         mode;

        tbl[0] = '{8'hA5, 0, 8'h00, (PAR == 1) ? 45 : 41, (PAR == 1) ? 1'b0 : 1'b1};
        tbl[1] = '{8'hA5, 1, 8'h00, (PAR == 1) ? 45 : 41, (PAR == 1) ? 1'b0 : 1'b1};
        tbl[2] = '{8'h81, 2, 8'h7E, (PAR == 1) ? 45 : 41, (PAR == 1) ? 1'b0 : 1'b1};
        tbl[3] = '{8'h7E, 0, 8'h00, (PAR == 1) ? 45 : 41, (PAR == 1) ? 1'b0 : 1'b1};
        tbl[4] = '{8'hA4, 0, 8'h00, (PAR == 1) ? 45 : 41, 1'b1};

        // Reset held with LOAD asserted: nothing may start.
        RST = 1'b1; LOAD = 1'b1; DATA_IN = 8'hA5; LOAD1 = 1'b0; DATA1 = 8'h00;
        repeat (2) begin
            @(negedge CLK);
            check("rst_tx", TX, 1);
            check("rst_ready", READY, 1);
            check("rst_done", DONE, 0);
        end
        RST = 1'b0; LOAD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("post_rst_tx", TX, 1);
            check("post_rst_ready", READY, 1);
        end

        for (int i = 0; i < 5; i++) begin
            frame(tbl[i].w, tbl[i].mode, tbl[i].nxt, done_at, after);
            check("tbl_done_cycle", done_at, tbl[i].exp_done);
            check("tbl_bit_after_data", after, tbl[i].exp_after);
            if (tbl[i].mode != 2) idle_cycles(2);
        end

        // Reset during data bit 3 abandons the frame without DONE.
        LOAD = 1'b1; DATA_IN = 8'hA5;
        for (int k = 1; k <= 4 * B + 2; k++) begin
            @(negedge CLK);
            LOAD = 1'b0;
        end
        check("pre_rst_tx", TX, exp_tx(8'hA5, 4 * B + 2, B));
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_tx", TX, 1);
        check("midrst_ready", READY, 1);
        check("midrst_done", DONE, 0);
        idle_cycles(FL * B + 4);
        frame(8'h5A, 0, 8'h00, done_at, after);
        check("after_rst_done_cycle", done_at, FL * B + 1);
        idle_cycles(1);

        // Random words, some chained back-to-back.
        w = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            mode = $urandom_range(0, 2);
            nxt  = 8'($urandom);
            frame(w, mode, nxt, done_at, after);
            check("rand_done_cycle", done_at, FL * B + 1);
            if (mode == 2) begin
                w = nxt;
            end else begin
                idle_cycles($urandom_range(1, 3));
                w = 8'($urandom);
            end
        end

        // BAUD_DIV=1: one cycle per bit.
        LOAD1 = 1'b1; DATA1 = 8'hFF;
        done_at = -1;
        for (int k = 1; k <= FL + 1; k++) begin
            @(negedge CLK);
            LOAD1 = 1'b0;
            check("b1_tx", TX1, exp_tx(8'hFF, k, 1));
            if (DONE1 === 1'b1 && done_at < 0) done_at = k;
        end
        check("b1_done_cycle", done_at, (PAR == 1) ? 12 : 11);
        @(negedge CLK);
        check("b1_done_pulse", DONE1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
